output_port_scheduler: RTL and testbench

//   Schedules one router output channel of a test_engine_node among five requesters: x+, y+, x-, y- inputs and the local PE.

---
 rtl/output_port_scheduler.sv | 123 ++++++++++++
 tb/tb_output_port_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/output_port_scheduler.sv
// Output-channel scheduler: packet-granular round-robin among five requesters
// (x+, y+, x-, y-, local PE) with downstream credit tracking.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no grant; pick the next requester in round-robin order
// ACTIVE | grant held until PACKET_FLITS flits have crossed the channel
module output_port_scheduler #(
  parameter int BUFFER_DEPTH = 5,
  parameter int PACKET_FLITS = 4,
  localparam int CW = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    request_din,
  input  logic          credit_in_din,
  output logic [4:0]    grant_dout,
  output logic          xfer_dout,
  output logic [CW-1:0] credit_count_dout,
  output logic          busy_dout,
  output logic          overflow_err_dout
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam int FW = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
  localparam logic [FW-1:0] LAST_FLIT = FW'(PACKET_FLITS - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(BUFFER_DEPTH);

  logic [0:0]    state;
  logic [2:0]    ptr;
  logic [2:0]    grant_idx;
  logic [FW-1:0] flit_cnt;

  logic          pick_valid;
  logic [2:0]    pick_idx;
  logic [3:0]    cand;

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

  // Round-robin search from ptr; iterating downward lets the closest hit win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    cand       = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (request_din[cand[2:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  // A flit moves only while a granted requester is ready and a slot is free.
  always_comb begin
    xfer_dout = (state == ACTIVE) && (|(request_din & grant_dout))
                && (credit_count_dout != '0);
  end

  assign busy_dout = (state == ACTIVE);

  // Packet FSM: grant load, flit counting and pointer advance on packet end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_dout <= 5'd0;
      grant_idx  <= 3'd0;
      ptr        <= 3'd0;
      flit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_dout <= 5'd1 << pick_idx;
            grant_idx  <= pick_idx;
            flit_cnt   <= '0;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (xfer_dout) begin
            if (flit_cnt == LAST_FLIT) begin
              grant_dout <= 5'd0;
              ptr        <= next_idx(grant_idx);
              flit_cnt   <= '0;
              state      <= IDLE;
            end else begin
              flit_cnt <= flit_cnt + FW'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          grant_dout <= 5'd0;
          flit_cnt   <= '0;
        end
      endcase
    end
  end

  // Credit counter: spend on xfer, refill on credit pulse, saturate and flag at the ceiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_count_dout <= CREDIT_MAX;
      overflow_err_dout <= 1'b0;
    end else begin
      case ({xfer_dout, credit_in_din})
        2'b10: credit_count_dout <= credit_count_dout - CW'(1);
        2'b01: begin
          if (credit_count_dout == CREDIT_MAX) overflow_err_dout <= 1'b1;
          else credit_count_dout <= credit_count_dout + CW'(1);
        end
        default: credit_count_dout <= credit_count_dout;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler.
module tb_output_port_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] request_din;
  logic       credit_in_din;
  logic [4:0] grant_dout;
  logic       xfer_dout;
  logic [2:0] credit_count_dout;
  logic       busy_dout;
  logic       overflow_err_dout;

  int checks = 0;
  int failures = 0;

  output_port_scheduler #(.BUFFER_DEPTH(5), .PACKET_FLITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .request_din(request_din),
    .credit_in_din(credit_in_din),
    .grant_dout(grant_dout),
    .xfer_dout(xfer_dout),
    .credit_count_dout(credit_count_dout),
    .busy_dout(busy_dout),
    .overflow_err_dout(overflow_err_dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    request_din = 5'd0;
    credit_in_din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (grant_dout !== 5'b00000) begin failures++; $display("FAIL reset_grant got=%b exp=00000", grant_dout); end
    checks++; if (busy_dout !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_dout); end
    checks++; if (credit_count_dout !== 3'd5) begin failures++; $display("FAIL reset_credit got=%0d exp=5", credit_count_dout); end
    checks++; if (overflow_err_dout !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_err_dout); end
    checks++; if (xfer_dout !== 1'b0) begin failures++; $display("FAIL reset_xfer got=%b exp=0", xfer_dout); end
  endtask

  task automatic test_single_requester();
    apply_reset();
    request_din = 5'b00001;
    step();
    checks++; if (grant_dout !== 5'b00001) begin failures++; $display("FAIL single_grant got=%b exp=00001", grant_dout); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (xfer_dout !== 1'b1) begin failures++; $display("FAIL single_xfer flit=%0d got=%b exp=1", i, xfer_dout); end
      checks++; if (credit_count_dout !== 3'(5 - i)) begin failures++; $display("FAIL single_credit flit=%0d got=%0d exp=%0d", i, credit_count_dout, 5 - i); end
      step();
    end
    checks++; if (grant_dout !== 5'b00000) begin failures++; $display("FAIL single_gap_grant got=%b exp=00000", grant_dout); end
    checks++; if (xfer_dout !== 1'b0) begin failures++; $display("FAIL single_gap_xfer got=%b exp=0", xfer_dout); end
    checks++; if (busy_dout !== 1'b0) begin failures++; $display("FAIL single_gap_busy got=%b exp=0", busy_dout); end
    checks++; if (credit_count_dout !== 3'd1) begin failures++; $display("FAIL single_credit_after got=%0d exp=1", credit_count_dout); end
    step();
    checks++; if (grant_dout !== 5'b00001) begin failures++; $display("FAIL single_regrant got=%b exp=00001", grant_dout); end
    checks++; if (xfer_dout !== 1'b1) begin failures++; $display("FAIL single_regrant_xfer got=%b exp=1", xfer_dout); end
    request_din = 5'd0;
  endtask

  task automatic test_round_robin();
    logic [4:0] order [6];
    int n;
    int bound;
    order[0] = 5'b00001; order[1] = 5'b00010; order[2] = 5'b00100;
    order[3] = 5'b01000; order[4] = 5'b10000; order[5] = 5'b00001;
    apply_reset();
    request_din = 5'b11111;
    for (int p = 0; p < 6; p++) begin
      bound = 0;
      while (grant_dout == 5'd0 && bound < 10) begin step(); bound++; end
      checks++; if (grant_dout !== order[p]) begin failures++; $display("FAIL rr_order pkt=%0d got=%b exp=%b", p, grant_dout, order[p]); end
      n = 0;
      bound = 0;
      while (grant_dout != 5'd0 && bound < 20) begin
        credit_in_din = xfer_dout;
        if (xfer_dout) n++;
        step();
        bound++;
      end
      credit_in_din = 1'b0;
      checks++; if (n !== 4) begin failures++; $display("FAIL rr_len pkt=%0d got=%0d exp=4", p, n); end
    end
    checks++; if (credit_count_dout !== 3'd5) begin failures++; $display("FAIL rr_credit got=%0d exp=5", credit_count_dout); end
    checks++; if (overflow_err_dout !== 1'b0) begin failures++; $display("FAIL rr_overflow got=%b exp=0", overflow_err_dout); end
    request_din = 5'd0;
  endtask

  task automatic test_credit_starve();
    apply_reset();
    request_din = 5'b00100;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (xfer_dout !== 1'b1) begin failures++; $display("FAIL starve_p1_xfer flit=%0d got=%b exp=1", i, xfer_dout); end
      step();
    end
    step();
    checks++; if (grant_dout !== 5'b00100) begin failures++; $display("FAIL starve_regrant got=%b exp=00100", grant_dout); end
    checks++; if (xfer_dout !== 1'b1) begin failures++; $display("FAIL starve_last_xfer got=%b exp=1", xfer_dout); end
    step();
    checks++; if (credit_count_dout !== 3'd0) begin failures++; $display("FAIL starve_zero got=%0d exp=0", credit_count_dout); end
    checks++; if (xfer_dout !== 1'b0) begin failures++; $display("FAIL starve_blocked got=%b exp=0", xfer_dout); end
    checks++; if (busy_dout !== 1'b1) begin failures++; $display("FAIL starve_busy got=%b exp=1", busy_dout); end
    step();
    checks++; if (credit_count_dout !== 3'd0) begin failures++; $display("FAIL starve_no_underflow got=%0d exp=0", credit_count_dout); end
    credit_in_din = 1'b1;
    step();
    credit_in_din = 1'b0;
    checks++; if (credit_count_dout !== 3'd1) begin failures++; $display("FAIL starve_refill got=%0d exp=1", credit_count_dout); end
    checks++; if (xfer_dout !== 1'b1) begin failures++; $display("FAIL starve_one_xfer got=%b exp=1", xfer_dout); end
    step();
    checks++; if (credit_count_dout !== 3'd0) begin failures++; $display("FAIL starve_spent got=%0d exp=0", credit_count_dout); end
    checks++; if (xfer_dout !== 1'b0) begin failures++; $display("FAIL starve_blocked_again got=%b exp=0", xfer_dout); end
    request_din = 5'd0;
  endtask

  task automatic test_overflow();
    apply_reset();
    credit_in_din = 1'b1;
    step();
    credit_in_din = 1'b0;
    checks++; if (credit_count_dout !== 3'd5) begin failures++; $display("FAIL ovf_hold got=%0d exp=5", credit_count_dout); end
    checks++; if (overflow_err_dout !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_err_dout); end
    repeat (10) step();
    checks++; if (overflow_err_dout !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err_dout); end
    request_din = 5'b00001;
    step();
    step();
    step();
    checks++; if (credit_count_dout !== 3'd3) begin failures++; $display("FAIL ovf_pre_coincide got=%0d exp=3", credit_count_dout); end
    checks++; if (xfer_dout !== 1'b1) begin failures++; $display("FAIL ovf_coincide_xfer got=%b exp=1", xfer_dout); end
    credit_in_din = 1'b1;
    step();
    credit_in_din = 1'b0;
    checks++; if (credit_count_dout !== 3'd3) begin failures++; $display("FAIL ovf_coincide got=%0d exp=3", credit_count_dout); end
    request_din = 5'd0;
  endtask

  task automatic test_stall();
    apply_reset();
    request_din = 5'b00001;
    step();
    step();
    request_din = 5'b00010;
    #1;
    checks++; if (xfer_dout !== 1'b0) begin failures++; $display("FAIL stall_xfer got=%b exp=0", xfer_dout); end
    repeat (3) step();
    checks++; if (grant_dout !== 5'b00001) begin failures++; $display("FAIL stall_hold got=%b exp=00001", grant_dout); end
    checks++; if (credit_count_dout !== 3'd4) begin failures++; $display("FAIL stall_credit got=%0d exp=4", credit_count_dout); end
    request_din = 5'b00011;
    repeat (3) step();
    checks++; if (grant_dout !== 5'b00000) begin failures++; $display("FAIL stall_release got=%b exp=00000", grant_dout); end
    step();
    checks++; if (grant_dout !== 5'b00010) begin failures++; $display("FAIL stall_next got=%b exp=00010", grant_dout); end
    request_din = 5'd0;
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    request_din = 5'b01000;
    step();
    checks++; if (grant_dout !== 5'b01000) begin failures++; $display("FAIL midrst_grant got=%b exp=01000", grant_dout); end
    step();
    #3;
    reset = 1'b1;
    #1;
    checks++; if (grant_dout !== 5'b00000) begin failures++; $display("FAIL midrst_grant_clr got=%b exp=00000", grant_dout); end
    checks++; if (busy_dout !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_dout); end
    checks++; if (credit_count_dout !== 3'd5) begin failures++; $display("FAIL midrst_credit got=%0d exp=5", credit_count_dout); end
    request_din = 5'b10000;
    step();
    reset = 1'b0;
    step();
    checks++; if (grant_dout !== 5'b10000) begin failures++; $display("FAIL midrst_pe_first got=%b exp=10000", grant_dout); end
    request_din = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    request_din = 5'd0;
    credit_in_din = 1'b0;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_credit_starve();
    test_overflow();
    test_stall();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
